// File: rtl/fft_pkg.sv
// Shared constants, sample type and helpers for the 32-point FFT output reorder stage.
package fft_pkg;

  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int DW    = 22;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } sample_t;

  typedef enum logic {
    IDLE,
    READ
  } rd_state_t;

  function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] a);
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two 32-entry complex banks: synchronous write port, asynchronous read port.
import fft_pkg::*;

module fft_pingpong_ram (
  input  logic             clk,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [LOG2N-1:0] wr_addr,
  input  sample_t          wr_data,
  input  logic             rd_bank,
  input  logic [LOG2N-1:0] rd_addr,
  output sample_t          rd_data
);

  sample_t mem [2][N];

  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/fft_reorder_32.sv
// Re-emits bit-reversed FFT frames in natural bin order using ping-pong banks.
import fft_pkg::*;

module fft_reorder_32 (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [DW-1:0]    in_real,
  input  logic signed [DW-1:0]    in_imag,
  output logic                    out_valid,
  output logic signed [DW-1:0]    out_real,
  output logic signed [DW-1:0]    out_imag,
  output logic [LOG2N-1:0]        out_index,
  output logic                    out_last,
  output logic                    busy
);

  logic [LOG2N-1:0] wr_cnt, wr_cnt_n;
  logic             wr_bank, wr_bank_n;
  rd_state_t        rd_state, rd_state_n;
  logic [LOG2N-1:0] rd_cnt, rd_cnt_n;
  logic             rd_bank, rd_bank_n;
  logic             complete;
  sample_t          wr_data, rd_data;

  logic                 out_valid_n, out_last_n, busy_n;
  logic signed [DW-1:0] out_real_n, out_imag_n;
  logic [LOG2N-1:0]     out_index_n;

  assign wr_data  = '{re: in_real, im: in_imag};
  assign complete = in_valid && (wr_cnt == LOG2N'(N - 1));

  fft_pingpong_ram u_ram (
    .clk     (clk),
    .we      (in_valid && !rst),
    .wr_bank (wr_bank),
    .wr_addr (bitrev5(wr_cnt)),
    .wr_data (wr_data),
    .rd_bank (rd_bank),
    .rd_addr (rd_cnt),
    .rd_data (rd_data)
  );

  always_comb begin
    wr_cnt_n    = wr_cnt;
    wr_bank_n   = wr_bank;
    rd_state_n  = rd_state;
    rd_cnt_n    = rd_cnt;
    rd_bank_n   = rd_bank;
    out_valid_n = 1'b0;
    out_last_n  = 1'b0;
    out_real_n  = out_real;
    out_imag_n  = out_imag;
    out_index_n = out_index;

    if (in_valid) wr_cnt_n = wr_cnt + LOG2N'(1);

    case (rd_state)
      READ: begin
        out_real_n  = rd_data.re;
        out_imag_n  = rd_data.im;
        out_index_n = rd_cnt;
        out_valid_n = 1'b1;
        out_last_n  = (rd_cnt == LOG2N'(N - 1));
        rd_cnt_n    = rd_cnt + LOG2N'(1);
        if (rd_cnt == LOG2N'(N - 1)) rd_state_n = IDLE;
      end
      default: ;
    endcase

    // A completing frame overrides the end-of-read return to IDLE, giving gapless back-to-back output.
    if (complete) begin
      wr_bank_n  = ~wr_bank;
      rd_bank_n  = wr_bank;
      rd_state_n = READ;
      rd_cnt_n   = '0;
    end

    busy_n = (wr_cnt_n != '0) || (rd_state_n == READ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_state  <= IDLE;
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_index <= '0;
      busy      <= 1'b0;
    end else begin
      wr_cnt    <= wr_cnt_n;
      wr_bank   <= wr_bank_n;
      rd_state  <= rd_state_n;
      rd_cnt    <= rd_cnt_n;
      rd_bank   <= rd_bank_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      out_real  <= out_real_n;
      out_imag  <= out_imag_n;
      out_index <= out_index_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_fft_reorder_32.sv
// Scoreboard bench for fft_reorder_32: expected natural-order frames queued at input time.
import fft_pkg::*;

module tb_fft_reorder_32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [DW-1:0] in_real, in_imag;
  logic                 out_valid, out_last, busy;
  logic signed [DW-1:0] out_real, out_imag;
  logic [LOG2N-1:0]     out_index;

  fft_reorder_32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [LOG2N-1:0]     idx;
    logic                 last;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] fr_re [32];
  logic signed [DW-1:0] fr_im [32];
  logic signed [DW-1:0] last_re, last_im;
  int   e0, first_cyc, gaps, busy_low;
  bit   check_busy, writing;

  function automatic int tb_rev(input int a);
    int r = 0;
    for (int b = 0; b < 5; b++) if (a & (1 << b)) r |= 1 << (4 - b);
    return r;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int j = 0; j < 32; j++) begin
      e.re   = fr_re[tb_rev(j)];
      e.im   = fr_im[tb_rev(j)];
      e.idx  = LOG2N'(j);
      e.last = (j == 31);
      exp_q.push_back(e);
    end
    last_re = fr_re[31];
    last_im = fr_im[31];
  endtask

  task automatic fill_ramp(input int base);
    for (int n = 0; n < 32; n++) begin
      fr_re[n] = DW'(base + n);
      fr_im[n] = DW'(-(base + n));
    end
  endtask

  // Called #1 after a posedge; leaves in_valid low #1 after the capture of sample 31.
  task automatic send_frame(input int gap);
    for (int n = 0; n < 32; n++) begin
      in_valid = 1'b1;
      in_real  = fr_re[n];
      in_imag  = fr_im[n];
      if (n == 31) begin
        e0 = cyc + 1;
        push_frame();
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      writing  = (n != 31);
      if (n != 31) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic collect(input int n, input int budget);
    exp_t e;
    int got = 0;
    int waited = 0;
    first_cyc = -1;
    gaps      = 0;
    busy_low  = 0;
    while (got < n && waited < budget) begin
      @(negedge clk);
      waited++;
      if (check_busy && writing && busy !== 1'b1) busy_low++;
      if (out_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_output: got out_valid=1 idx=%0d, required no output", out_index);
        end else begin
          e = exp_q.pop_front();
          if (out_real !== e.re || out_imag !== e.im || out_index !== e.idx || out_last !== e.last) begin
            errors++;
            $display("FAIL sample: got re=%0d im=%0d idx=%0d last=%0b, required re=%0d im=%0d idx=%0d last=%0b",
                     out_real, out_imag, out_index, out_last, e.re, e.im, e.idx, e.last);
          end
        end
        got++;
      end else if (first_cyc >= 0) begin
        gaps++;
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL collect_timeout: got %0d outputs, required %0d", got, n);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid: got %b, required 0", name, out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b, required 0", name, busy); end
    checks++;
    if (out_last !== 1'b0) begin errors++; $display("FAIL %s out_last: got %b, required 0", name, out_last); end
    checks++;
    if (out_index !== '0) begin errors++; $display("FAIL %s out_index: got %0d, required 0", name, out_index); end
    checks++;
    if (out_real !== '0) begin errors++; $display("FAIL %s out_real: got %0d, required 0", name, out_real); end
    checks++;
    if (out_imag !== '0) begin errors++; $display("FAIL %s out_imag: got %0d, required 0", name, out_imag); end
  endtask

  task automatic check_latency(input string name, input int expected);
    checks++;
    if (first_cyc !== expected) begin
      errors++;
      $display("FAIL %s latency: first out_valid at cycle %0d, required %0d", name, first_cyc, expected);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_real = '0;
    in_imag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_continuous();
    fill_ramp(0);
    fork
      send_frame(0);
      collect(32, 200);
    join
    check_latency("continuous", e0 + 1);
  endtask

  task automatic test_back_to_back();
    int e0_first = 0;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          fill_ramp(100 * f);
          send_frame(0);
          if (f == 0) e0_first = e0;
        end
      end
      collect(96, 400);
    join
    check_latency("back_to_back", e0_first + 1);
    checks++;
    if (gaps !== 0) begin
      errors++;
      $display("FAIL back_to_back gaps: got %0d idle cycles, required 0", gaps);
    end
  endtask

  task automatic test_gapped();
    fill_ramp(40);
    check_busy = 1'b1;
    fork
      send_frame(2);
      collect(32, 400);
    join
    check_busy = 1'b0;
    check_latency("gapped", e0 + 1);
    checks++;
    if (busy_low !== 0) begin
      errors++;
      $display("FAIL gapped busy: got %0d low cycles during write, required 0", busy_low);
    end
  endtask

  task automatic test_reset_mid();
    fill_ramp(500);
    fork
      begin
        send_frame(0);
        for (int n = 0; n < 20; n++) begin
          in_valid = 1'b1;
          in_real  = DW'(900 + n);
          in_imag  = DW'(-(900 + n));
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
      collect(20, 200);
    join
    @(negedge clk);
    check_zero_outputs("reset_mid");
    exp_q.delete();
    @(posedge clk); #1;
    fill_ramp(700);
    fork
      send_frame(0);
      collect(32, 200);
    join
    check_latency("after_reset", e0 + 1);
  endtask

  task automatic test_extremes();
    for (int n = 0; n < 32; n++) begin
      fr_re[n] = (n % 2 == 0) ? DW'(-2097152) : DW'(2097151);
      fr_im[n] = (n % 2 == 0) ? DW'(2097151) : DW'(-2097152);
    end
    fork
      send_frame(0);
      collect(32, 200);
    join
    check_latency("extremes", e0 + 1);
  endtask

  task automatic test_idle_hold();
    int bad_valid = 0, bad_busy = 0, bad_idx = 0, bad_data = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || out_last !== 1'b0) bad_valid++;
      if (busy !== 1'b0) bad_busy++;
      if (out_index !== LOG2N'(31)) bad_idx++;
      if (out_real !== last_re || out_imag !== last_im) bad_data++;
    end
    checks++;
    if (bad_valid != 0) begin errors++; $display("FAIL idle out_valid: got %0d active cycles, required 0", bad_valid); end
    checks++;
    if (bad_busy != 0) begin errors++; $display("FAIL idle busy: got %0d high cycles, required 0", bad_busy); end
    checks++;
    if (bad_idx != 0) begin errors++; $display("FAIL idle out_index: got %0d cycles off 31 (now %0d), required 0", bad_idx, out_index); end
    checks++;
    if (bad_data != 0) begin
      errors++;
      $display("FAIL idle hold: got %0d changed cycles (re=%0d im=%0d), required hold re=%0d im=%0d",
               bad_data, out_real, out_imag, last_re, last_im);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL idle leftover: got %0d unread expected, required 0", exp_q.size()); end
  endtask

  initial begin
    check_busy = 1'b0;
    writing    = 1'b0;
    test_reset();
    test_continuous();
    test_back_to_back();
    repeat (40) @(posedge clk);
    #1;
    test_gapped();
    repeat (40) @(posedge clk);
    #1;
    test_reset_mid();
    repeat (40) @(posedge clk);
    #1;
    test_extremes();
    test_idle_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
